// File: rtl/run_controller_pkg.sv
// Shared types and default constants for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam int RUN_CTRL_RST_HOLD = 4;
  localparam int RUN_CTRL_TIMEOUT  = 200;

endpackage

// File: rtl/run_controller_if.sv
// Core-facing control/status bundle of the run controller.
interface run_controller_if #(
  parameter int CNT_W = 32
);
  logic             halt_i;
  logic             retire_i;
  logic             restart_i;
  logic             core_reset_o;
  logic             run_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] retire_cnt_o;

  modport master (
    output halt_i, retire_i, restart_i,
    input  core_reset_o, run_o, done_o, timeout_o, cycle_cnt_o, retire_cnt_o
  );

  modport slave (
    input  halt_i, retire_i, restart_i,
    output core_reset_o, run_o, done_o, timeout_o, cycle_cnt_o, retire_cnt_o
  );
endinterface

// File: rtl/run_controller_reset_sync.sv
// Two-flop synchroniser for reset deassertion; clears asynchronously on reset low.
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic sync_o
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[1];
endmodule

// File: rtl/run_controller.sv
// Core reset/run sequencer with cycle and retire counters.
// Watchdog (TIMEOUT state) is built only when RUN_CTRL_WATCHDOG_EN is defined.
//
// state   | meaning
// SYNC    | waiting for synchronised reset release
// HOLD    | core held in reset for RST_HOLD cycles
// RUN     | core running, counters active
// DONE    | core halted, results frozen
// TIMEOUT | watchdog expired, results frozen
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RST_HOLD = RUN_CTRL_RST_HOLD,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = RUN_CTRL_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  run_controller_if.slave  bus
);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0]  TMO_C     = CNT_W'(TIMEOUT);
`endif

  logic             sync_rel;
  run_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, cycle_inc;
  logic [CNT_W-1:0] retire_q, retire_d, retire_inc;
  logic             core_reset_q, core_reset_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  reset_sync u_reset_sync (
    .clk    (clk),
    .reset  (reset),
    .sync_o (sync_rel)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    cycle_inc  = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
    retire_inc = (retire_q == CNT_MAX) ? retire_q : retire_q + CNT_W'(1);

    case (state_q)
      ST_SYNC: begin
        if (sync_rel) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d = cycle_inc;
        if (bus.retire_i) retire_d = retire_inc;
        // halt takes priority over a simultaneous watchdog hit
        if (bus.halt_i) begin
          state_d = ST_DONE;
        end
`ifdef RUN_CTRL_WATCHDOG_EN
        else if (cycle_inc == TMO_C) begin
          state_d = ST_TIMEOUT;
        end
`endif
      end
      ST_DONE, ST_TIMEOUT: begin
        if (bus.restart_i) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          cycle_d  = '0;
          retire_d = '0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    core_reset_d = (state_d != ST_RUN);
    run_d        = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
    timeout_d    = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SYNC;
      hold_q       <= '0;
      cycle_q      <= '0;
      retire_q     <= '0;
      core_reset_q <= 1'b1;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
      core_reset_q <= core_reset_d;
      run_q        <= run_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.core_reset_o = core_reset_q;
  assign bus.run_o        = run_q;
  assign bus.done_o       = done_q;
`ifdef RUN_CTRL_WATCHDOG_EN
  assign bus.timeout_o    = timeout_q;
`else
  assign bus.timeout_o    = 1'b0;
`endif
  assign bus.cycle_cnt_o  = cycle_q;
  assign bus.retire_cnt_o = retire_q;
endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: randomized run sessions against a session-level model.
module tb_run_controller;
  localparam int RST_HOLD = 4;
  localparam int CNT_W    = 32;
  localparam int TMO      = 20;

  typedef struct {
    bit          to;
    int unsigned cyc;
    int unsigned ret;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  run_controller_if #(.CNT_W(CNT_W)) bus ();

  run_controller #(
    .RST_HOLD (RST_HOLD),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected result each time the DUT reports done, then
  // keeps checking that the reported result stays frozen.
  bit   done_prev;
  bit   have_cur;
  exp_t cur;
  initial begin
    done_prev = 1'b0;
    have_cur  = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.done_o === 1'b1 && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        cur      = sb_q.pop_front();
        have_cur = 1'b1;
        chk("sb_timeout", bus.timeout_o, cur.to);
        chk("sb_cycles", bus.cycle_cnt_o, cur.cyc);
        chk("sb_retires", bus.retire_cnt_o, cur.ret);
      end
    end else if (bus.done_o === 1'b1 && have_cur) begin
      chk("frozen_cycles", bus.cycle_cnt_o, cur.cyc);
      chk("frozen_retires", bus.retire_cnt_o, cur.ret);
      chk("frozen_timeout", bus.timeout_o, cur.to);
    end
    if (bus.done_o !== 1'b1) have_cur = 1'b0;
    done_prev = (bus.done_o === 1'b1);
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held for 3 cycles, then released; RUN expected at edge 3+RST_HOLD.
  task automatic reset_and_release();
    reset         = 1'b0;
    bus.halt_i    = 1'b0;
    bus.retire_i  = 1'b0;
    bus.restart_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core_reset", bus.core_reset_o, 1);
    chk("rst_run", bus.run_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_cycles", bus.cycle_cnt_o, 0);
    chk("rst_retires", bus.retire_cnt_o, 0);
    reset = 1'b1;
    for (int e = 1; e <= RST_HOLD + 2; e++) begin
      cycle();
      chk("rel_core_reset", bus.core_reset_o, 1);
      chk("rel_run", bus.run_o, 0);
    end
    cycle();
    chk("rel_run_entry", bus.run_o, 1);
    chk("rel_core_reset_low", bus.core_reset_o, 0);
    chk("rel_cycles", bus.cycle_cnt_o, 0);
    chk("rel_retires", bus.retire_cnt_o, 0);
  endtask

  // One run from RUN entry to halt (or watchdog), then park and restart.
  task automatic run_session(input int h);
    int unsigned lim;
    int unsigned sum;
    bit          to;
    bit          rb[$];
    bit          b;
    lim = h;
    to  = 1'b0;
    sum = 0;
`ifdef RUN_CTRL_WATCHDOG_EN
    if (h > TMO) begin
      lim = TMO;
      to  = 1'b1;
    end
`endif
    for (int i = 0; i < int'(lim); i++) begin
      b = 1'($urandom_range(0, 1));
      rb.push_back(b);
      sum += b;
    end
    sb_q.push_back('{to, lim, sum});

    for (int i = 1; i <= int'(lim); i++) begin
      bus.halt_i    = (i == h);
      bus.retire_i  = rb[i-1];
      bus.restart_i = ($urandom_range(0, 3) == 0);
      cycle();
      if (i < int'(lim)) chk("run_active", bus.run_o, 1);
    end
    bus.halt_i    = 1'b0;
    bus.restart_i = 1'b0;
    chk("end_done", bus.done_o, 1);
    chk("end_core_reset", bus.core_reset_o, 1);
    chk("end_run", bus.run_o, 0);
    chk("end_timeout", bus.timeout_o, to);

    repeat ($urandom_range(2, 6)) begin
      bus.halt_i   = 1'($urandom_range(0, 1));
      bus.retire_i = 1'($urandom_range(0, 1));
      cycle();
    end

    bus.restart_i = 1'b1;
    cycle();
    bus.restart_i = 1'b0;
    chk("rs_cycles", bus.cycle_cnt_o, 0);
    chk("rs_retires", bus.retire_cnt_o, 0);
    chk("rs_core_reset", bus.core_reset_o, 1);
    chk("rs_done", bus.done_o, 0);
    for (int k = 1; k < RST_HOLD; k++) begin
      bus.halt_i   = 1'($urandom_range(0, 1));
      bus.retire_i = 1'($urandom_range(0, 1));
      cycle();
      chk("rs_hold", bus.core_reset_o, 1);
    end
    bus.halt_i   = 1'b0;
    bus.retire_i = 1'b0;
    cycle();
    chk("rs_run_entry", bus.run_o, 1);
    chk("rs_core_reset_low", bus.core_reset_o, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_and_release();

    run_session(10);
    run_session(TMO);
    run_session(1);
    run_session(TMO + 1);
    for (int s = 0; s < 8; s++) begin
      run_session($urandom_range(1, 2 * TMO));
    end
    run_session(1000);

    // asynchronous reset in the middle of a run
    repeat (10) begin
      bus.retire_i = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.retire_i = 1'b0;
    chk("mid_cycles", bus.cycle_cnt_o, 10);
    #2 reset = 1'b0;
    #1;
    chk("async_core_reset", bus.core_reset_o, 1);
    chk("async_run", bus.run_o, 0);
    chk("async_done", bus.done_o, 0);
    chk("async_cycles", bus.cycle_cnt_o, 0);
    chk("async_retires", bus.retire_cnt_o, 0);
    reset_and_release();
    run_session($urandom_range(1, 2 * TMO));

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
